// File: rtl/ws2811_frame_ctrl_if.sv
// Host-side write and bank-swap handshake for ws2811_frame_ctrl.
interface ws2811_frame_ctrl_if #(
  parameter int unsigned AW = 3
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          swap_req;
  logic          swap_ack;

  modport master (
    output wr_valid, wr_addr, wr_data, swap_req,
    input  wr_ready, swap_ack
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, swap_req,
    output wr_ready, swap_ack
  );
endinterface

// File: rtl/ws2811_frame_ctrl.sv
// Double-buffered WS2811 pixel store; the host fills the back bank and the swap lands on a frame wrap.
// Define WS2811_BRIGHTNESS_EN to add a global brightness input that scales every output channel.
module ws2811_frame_ctrl #(
  parameter int unsigned NUM_LEDS = 4,
  // One spare address code so that indices >= NUM_LEDS are representable and can be discarded.
  localparam int unsigned AW = $clog2(NUM_LEDS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  ws2811_frame_ctrl_if.slave  bus,
  input  logic [AW-1:0]       led_address,
`ifdef WS2811_BRIGHTNESS_EN
  input  logic [7:0]          brightness,
`endif
  output logic [7:0]          red_out,
  output logic [7:0]          green_out,
  output logic [7:0]          blue_out,
  output logic [15:0]         frame_count
);

  localparam int unsigned   IW   = $clog2(NUM_LEDS);
  localparam logic [AW-1:0] LAST = AW'(NUM_LEDS - 1);

  if (NUM_LEDS < 2) begin : g_num_leds_check
    $error("ws2811_frame_ctrl: NUM_LEDS must be at least 2");
  end

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t        state;
  logic          front;
  logic [AW-1:0] prev_addr;
  logic          swap_ack_q;
  logic [23:0]   bank [2][NUM_LEDS];

  logic          boundary_c;
  logic          wr_fire_c;
  logic [23:0]   pixel_c;

  // A frame ends when the driver wraps from the last LED back to LED 0.
  assign boundary_c   = (prev_addr == LAST) && (led_address == '0);
  assign bus.wr_ready = (state == IDLE) && reset;
  assign wr_fire_c    = bus.wr_valid && bus.wr_ready;
  assign bus.swap_ack = swap_ack_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      front       <= 1'b0;
      prev_addr   <= '0;
      swap_ack_q  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      prev_addr  <= led_address;
      swap_ack_q <= 1'b0;
      if (boundary_c) frame_count <= frame_count + 16'd1;
      case (state)
        IDLE: begin
          // A request arriving on a boundary cycle waits for the following frame.
          if (bus.swap_req) state <= PENDING;
        end
        PENDING: begin
          if (boundary_c) begin
            front      <= ~front;
            state      <= IDLE;
            swap_ack_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Banks carry no reset so a frame survives a controller reset.
  always_ff @(posedge clk) begin
    if (wr_fire_c && (bus.wr_addr <= LAST)) begin
      bank[~front][IW'(bus.wr_addr)] <= bus.wr_data;
    end
  end

  assign pixel_c = (led_address <= LAST) ? bank[front][IW'(led_address)] : 24'h0;

`ifdef WS2811_BRIGHTNESS_EN
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(c) * (16'(b) + 16'd1);
    return 8'(prod >> 8);
  endfunction

  assign red_out   = scale(pixel_c[23:16], brightness);
  assign green_out = scale(pixel_c[15:8],  brightness);
  assign blue_out  = scale(pixel_c[7:0],   brightness);
`else
  assign red_out   = pixel_c[23:16];
  assign green_out = pixel_c[15:8];
  assign blue_out  = pixel_c[7:0];
`endif

endmodule
